// File: rtl/mux4_rr_sched_pkg.sv
// mux4_rr_sched_pkg: shared definitions for the 4-channel byte scheduler.
//   state_e  : scheduler FSM encoding (ARB / BURST_HOLD)
//   CH0..CH3 : channel index constants
//   onehot4  : 2-bit index -> 4-bit one-hot
package mux4_rr_sched_pkg;

  typedef enum logic {
    ARB        = 1'b0,
    BURST_HOLD = 1'b1
  } state_e;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// mux4_rr_sched_if: producer/consumer bus of the 4:1 byte scheduler.
//   REQ[3:0]   per-channel data valid        A,B,C,D  channel 0..3 data
//   ACK[3:0]   one-hot capture pulse         F        selected byte
//   F_VALID    F holds a byte                F_READY  consumer accepts F
//   S[1:0]     index of channel whose byte is in F
// master: the environment (producers + consumer); slave: the scheduler.
interface mux4_rr_sched_if #(parameter int WIDTH = 8);
  logic [3:0]       REQ;
  logic [WIDTH-1:0] A, B, C, D;
  logic [3:0]       ACK;
  logic [WIDTH-1:0] F;
  logic             F_VALID;
  logic             F_READY;
  logic [1:0]       S;

  modport master (output REQ, A, B, C, D, F_READY,
                  input  ACK, F, F_VALID, S);
  modport slave  (input  REQ, A, B, C, D, F_READY,
                  output ACK, F, F_VALID, S);
endinterface

// File: rtl/mux4_rr_sched_rr_pick4.sv
// rr_pick4: combinational 4-way rotating priority picker.
//   req_i[3:0] requests, ptr_i[1:0] highest-priority index
//   gnt_o[1:0] first requester scanning ptr_i upward with wrap, any_o = |req_i
module rr_pick4
  import mux4_rr_sched_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    gnt_o = ptr_i;
    any_o = 1'b0;
    idx   = ptr_i;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_i + 2'(k);
      if (req_i[idx]) begin
        gnt_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: arbitrates four byte producers onto one valid/ready slot.
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   bus        mux4_rr_sched_if.slave (REQ, A..D, F_READY in; ACK, F, F_VALID, S out)
// Parameters: WIDTH (data width), BURST (1..15 consecutive beats per channel).
// Build option: MUX4_SCHED_FIXED_PRIO_EN -> fixed priority (ch0 highest), no
// rotation pointer; burst limit still applies.
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input logic              CLK,
  input logic              RST,
  mux4_rr_sched_if.slave   bus
);

  if (BURST < 1 || BURST > 15) begin : g_burst_range
    $error("mux4_rr_sched: BURST must be in 1..15");
  end

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_e           state_q;
  logic [1:0]       owner_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] f_q;
  logic [1:0]       s_q;
  logic [3:0]       ack_q;
  logic             vld_q;

  logic [1:0]       pick_ptr;
  logic [1:0]       pgnt;
  logic             pany;
  logic             hold_owner;
  logic [1:0]       gnt;
  logic             any;
  logic             take;
  logic [WIDTH-1:0] dsel;

  // Owner keeps the grant only while it still requests; once it drops,
  // the same cycle re-arbitrates starting just past the owner.
  assign hold_owner = (state_q == BURST_HOLD) && bus.REQ[owner_q];

`ifdef MUX4_SCHED_FIXED_PRIO_EN
  assign pick_ptr = CH0;
`else
  logic [1:0] ptr_q;
  assign pick_ptr = (state_q == BURST_HOLD) ? owner_q + 2'd1 : ptr_q;
`endif

  rr_pick4 u_pick (
    .req_i (bus.REQ),
    .ptr_i (pick_ptr),
    .gnt_o (pgnt),
    .any_o (pany)
  );

  assign gnt  = hold_owner ? owner_q : pgnt;
  assign any  = hold_owner | pany;
  assign take = any && (!vld_q || bus.F_READY);

  // 4:1 byte mux, select = current grant.
  always_comb begin
    dsel = bus.A;
    unique case (gnt)
      CH0: dsel = bus.A;
      CH1: dsel = bus.B;
      CH2: dsel = bus.C;
      CH3: dsel = bus.D;
      default: dsel = bus.A;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB;
      owner_q <= CH0;
      cnt_q   <= 4'd0;
      f_q     <= '0;
      s_q     <= CH0;
      ack_q   <= 4'b0000;
      vld_q   <= 1'b0;
`ifndef MUX4_SCHED_FIXED_PRIO_EN
      ptr_q   <= CH0;
`endif
    end else begin
      ack_q <= 4'b0000;
      if (take) begin
        f_q   <= dsel;
        s_q   <= gnt;
        vld_q <= 1'b1;
        ack_q <= onehot4(gnt);
        if (hold_owner) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q + 4'd1 == BURST_C) state_q <= ARB;
        end else begin
          // Fresh grant: pointer moves past the winner now; a burst
          // ends on the same pointer value, so no update is needed then.
          cnt_q   <= 4'd1;
          owner_q <= gnt;
          state_q <= (BURST > 1) ? BURST_HOLD : ARB;
`ifndef MUX4_SCHED_FIXED_PRIO_EN
          ptr_q   <= gnt + 2'd1;
`endif
        end
      end else begin
        if (bus.F_READY) vld_q <= 1'b0;
        if (!any) state_q <= ARB;
      end
    end
  end

  assign bus.F       = f_q;
  assign bus.S       = s_q;
  assign bus.ACK     = ack_q;
  assign bus.F_VALID = vld_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
module tb_mux4_rr_sched;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   fails  = 0;

  always #5 CLK = ~CLK;

  mux4_rr_sched_if #(.WIDTH(8)) bus1 ();
  mux4_rr_sched_if #(.WIDTH(8)) bus4 ();

  mux4_rr_sched #(.WIDTH(8), .BURST(1)) u_b1 (.CLK(CLK), .RST(RST), .bus(bus1));
  mux4_rr_sched #(.WIDTH(8), .BURST(4)) u_b4 (.CLK(CLK), .RST(RST), .bus(bus4));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_data(input logic [7:0] a, b, c, d);
    bus1.A = a; bus1.B = b; bus1.C = c; bus1.D = d;
    bus4.A = a; bus4.B = b; bus4.C = c; bus4.D = d;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus1.REQ = 4'hF; bus4.REQ = 4'hF;
    bus1.F_READY = 1'b1; bus4.F_READY = 1'b1;
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (bus1.F !== 8'h00) begin fails++; $display("FAIL reset_F got %h want 00", bus1.F); end
      checks++; if (bus1.F_VALID !== 1'b0) begin fails++; $display("FAIL reset_FV got %b want 0", bus1.F_VALID); end
      checks++; if (bus1.ACK !== 4'b0000) begin fails++; $display("FAIL reset_ACK got %b want 0000", bus1.ACK); end
      checks++; if (bus1.S !== 2'b00) begin fails++; $display("FAIL reset_S got %0d want 0", bus1.S); end
      checks++; if (bus4.F_VALID !== 1'b0 || bus4.ACK !== 4'b0000 || bus4.F !== 8'h00 || bus4.S !== 2'b00)
        begin fails++; $display("FAIL reset_b4 got F=%h FV=%b ACK=%b S=%0d want 00/0/0000/0", bus4.F, bus4.F_VALID, bus4.ACK, bus4.S); end
    end
    RST = 1'b0;
    bus1.REQ = 4'h0; bus4.REQ = 4'h0;
  endtask

  task automatic test_single();
    do_reset();
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus1.REQ = 4'b0001;
    tick();
    checks++; if (bus1.F !== 8'h08) begin fails++; $display("FAIL single_F got %h want 08", bus1.F); end
    checks++; if (bus1.S !== 2'd0) begin fails++; $display("FAIL single_S got %0d want 0", bus1.S); end
    checks++; if (bus1.ACK !== 4'b0001) begin fails++; $display("FAIL single_ACK got %b want 0001", bus1.ACK); end
    checks++; if (bus1.F_VALID !== 1'b1) begin fails++; $display("FAIL single_FV got %b want 1", bus1.F_VALID); end
    bus1.REQ = 4'b0000;
    tick();
    checks++; if (bus1.ACK !== 4'b0000 || bus1.F_VALID !== 1'b0)
      begin fails++; $display("FAIL single_drain got ACK=%b FV=%b want 0000/0", bus1.ACK, bus1.F_VALID); end
  endtask

`ifndef MUX4_SCHED_FIXED_PRIO_EN
  task automatic test_rr_rotation();
    logic [7:0] ef [5];
    logic [1:0] es [5];
    logic [3:0] ea [5];
    ef = '{8'h08, 8'h41, 8'h03, 8'h4B, 8'h08};
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    ea = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus1.REQ = 4'hF; bus1.F_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus1.F !== ef[i] || bus1.S !== es[i] || bus1.ACK !== ea[i])
        begin fails++; $display("FAIL rr_beat%0d got F=%h S=%0d ACK=%b want %h/%0d/%b", i, bus1.F, bus1.S, bus1.ACK, ef[i], es[i], ea[i]); end
    end
    bus1.REQ = 4'h0;
  endtask

  task automatic test_burst();
    logic [1:0] es [9];
    es = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus4.REQ = 4'b0011; bus4.F_READY = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (bus4.S !== es[i] || bus4.ACK !== (4'b0001 << es[i]))
        begin fails++; $display("FAIL burst_beat%0d got S=%0d ACK=%b want S=%0d", i, bus4.S, bus4.ACK, es[i]); end
    end
    // Owner drops after two beats: channel 1 must take over on the next edge.
    do_reset();
    bus4.REQ = 4'b0011;
    tick();
    tick();
    checks++; if (bus4.S !== 2'd0 || bus4.ACK !== 4'b0001)
      begin fails++; $display("FAIL burst_early_pre got S=%0d ACK=%b want 0/0001", bus4.S, bus4.ACK); end
    bus4.REQ = 4'b0010;
    tick();
    checks++; if (bus4.S !== 2'd1 || bus4.ACK !== 4'b0010 || bus4.F !== 8'h41)
      begin fails++; $display("FAIL burst_early_drop got S=%0d ACK=%b F=%h want 1/0010/41", bus4.S, bus4.ACK, bus4.F); end
    bus4.REQ = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus1.REQ = 4'hF; bus1.F_READY = 1'b1;
    tick();
    checks++; if (bus1.F !== 8'h08 || bus1.S !== 2'd0)
      begin fails++; $display("FAIL bp_load got F=%h S=%0d want 08/0", bus1.F, bus1.S); end
    bus1.F_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_data(8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i));
      bus1.REQ = (i % 2 == 0) ? 4'b0110 : 4'hF;
      tick();
      checks++; if (bus1.F !== 8'h08 || bus1.S !== 2'd0 || bus1.ACK !== 4'b0000 || bus1.F_VALID !== 1'b1)
        begin fails++; $display("FAIL bp_stall%0d got F=%h S=%0d ACK=%b FV=%b want 08/0/0000/1", i, bus1.F, bus1.S, bus1.ACK, bus1.F_VALID); end
    end
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus1.REQ = 4'hF; bus1.F_READY = 1'b1;
    tick();
    checks++; if (bus1.F !== 8'h41 || bus1.S !== 2'd1 || bus1.ACK !== 4'b0010 || bus1.F_VALID !== 1'b1)
      begin fails++; $display("FAIL bp_release got F=%h S=%0d ACK=%b FV=%b want 41/1/0010/1", bus1.F, bus1.S, bus1.ACK, bus1.F_VALID); end
    bus1.REQ = 4'h0;
  endtask

  task automatic test_midop_reset();
    do_reset();
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus4.REQ = 4'b0011; bus4.F_READY = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    checks++; if (bus4.F_VALID !== 1'b0 || bus4.ACK !== 4'b0000 || bus4.F !== 8'h00 || bus4.S !== 2'd0)
      begin fails++; $display("FAIL midrst got FV=%b ACK=%b F=%h S=%0d want 0/0000/00/0", bus4.F_VALID, bus4.ACK, bus4.F, bus4.S); end
    RST = 1'b0;
    bus4.REQ = 4'b0101;
    tick();
    checks++; if (bus4.S !== 2'd0 || bus4.F !== 8'h08 || bus4.ACK !== 4'b0001)
      begin fails++; $display("FAIL midrst_first got S=%0d F=%h ACK=%b want 0/08/0001", bus4.S, bus4.F, bus4.ACK); end
    bus4.REQ = 4'b0000;
  endtask
`else
  task automatic test_fixed_prio();
    do_reset();
    set_data(8'h08, 8'h41, 8'h03, 8'h4B);
    bus1.REQ = 4'b1001; bus1.F_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus1.S !== 2'd0 || bus1.ACK !== 4'b0001 || bus1.F !== 8'h08)
        begin fails++; $display("FAIL fixed_beat%0d got S=%0d ACK=%b F=%h want 0/0001/08", i, bus1.S, bus1.ACK, bus1.F); end
    end
    bus1.REQ = 4'b0000;
  endtask
`endif

  initial begin
    RST = 1'b1;
    bus1.REQ = 4'h0; bus4.REQ = 4'h0;
    bus1.F_READY = 1'b1; bus4.F_READY = 1'b1;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_single();
`ifndef MUX4_SCHED_FIXED_PRIO_EN
    test_rr_rotation();
    test_burst();
    test_backpressure();
    test_midop_reset();
`else
    test_fixed_prio();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
